// File: rtl/sram_bridge.sv
// sram_bridge: classic-cycle 16-bit slave bus to asynchronous SRAM with programmable wait states.
module sram_bridge #(
  parameter int AW      = 19,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic [63:0]   adr_i,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic          siz_i,
  input  logic [15:0]   dat_i,
  output logic          ack_o,
  output logic [15:0]   dat_o,
  output logic [AW-1:0] sram_a_o,
  output logic          sram_ce_no,
  output logic          sram_oe_no,
  output logic          sram_we_no,
  output logic          sram_lb_no,
  output logic          sram_ub_no,
  input  logic [15:0]   sram_d_i,
  output logic [15:0]   sram_d_o,
  output logic          sram_d_oe_o
);
  localparam int RW = (RD_WAIT < 1) ? 1 : RD_WAIT;
  localparam int WW = (WR_WAIT < 1) ? 1 : WR_WAIT;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, ACK} state_t;
  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, wd_q, wd_d, dat_q, dat_d;
  logic [AW-1:0] a_q, a_d;
  logic          we_q, we_d, siz_q, siz_d, lo_q, lo_d, act;
  logic          unused_adr;
  assign unused_adr = ^adr_i[63:AW+1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    dat_d   = dat_q;
    a_d     = a_q;
    we_d    = we_q;
    siz_d   = siz_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (cyc_i && stb_i) begin
        state_d = SETUP;
        a_d     = adr_i[AW:1];
        lo_d    = adr_i[0];
        we_d    = we_i;
        siz_d   = siz_i;
        wd_d    = siz_i ? dat_i : {2{dat_i[7:0]}};
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = we_q ? 16'(WW - 1) : 16'(RW - 1);
      end
      ACCESS: if (cnt_q == 16'd0) begin
        state_d = HOLD;
        if (!we_q) dat_d = siz_q ? sram_d_i : {8'h00, lo_q ? sram_d_i[15:8] : sram_d_i[7:0]};
      end else cnt_d = cnt_q - 16'd1;
      HOLD:    state_d = ACK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wd_q    <= '0;
      dat_q   <= '0;
      a_q     <= '0;
      we_q    <= 1'b0;
      siz_q   <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      dat_q   <= dat_d;
      a_q     <= a_d;
      we_q    <= we_d;
      siz_q   <= siz_d;
      lo_q    <= lo_d;
    end
  // Chip select, lanes and write data span SETUP through HOLD; strobes only ACCESS.
  assign act         = state_q == SETUP || state_q == ACCESS || state_q == HOLD;
  assign sram_ce_no  = !act;
  assign sram_oe_no  = !(state_q == ACCESS && !we_q);
  assign sram_we_no  = !(state_q == ACCESS && we_q);
  assign sram_lb_no  = !(act && (siz_q || !lo_q));
  assign sram_ub_no  = !(act && (siz_q || lo_q));
  assign sram_d_oe_o = act && we_q;
  assign sram_d_o    = wd_q;
  assign sram_a_o    = a_q;
  assign dat_o       = dat_q;
  assign ack_o       = state_q == ACK && cyc_i && stb_i;
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed checks of sram_bridge against a small behavioural SRAM.
module tb_sram_bridge;
  logic        clk = 1'b0, reset_ni = 1'b0;
  logic [63:0] adr = '0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, siz = 1'b0;
  logic [15:0] dat = '0;
  logic        ack, ce_n, oe_n, we_n, lb_n, ub_n, d_oe;
  logic [15:0] dat_o, d_i, d_o;
  logic [18:0] a;
  logic [15:0] mem [256];
  int          checks = 0, failures = 0;
  sram_bridge #(.AW(19), .RD_WAIT(2), .WR_WAIT(2)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .adr_i(adr), .cyc_i(cyc), .stb_i(stb),
    .we_i(we), .siz_i(siz), .dat_i(dat), .ack_o(ack), .dat_o(dat_o),
    .sram_a_o(a), .sram_ce_no(ce_n), .sram_oe_no(oe_n), .sram_we_no(we_n),
    .sram_lb_no(lb_n), .sram_ub_no(ub_n), .sram_d_i(d_i), .sram_d_o(d_o),
    .sram_d_oe_o(d_oe)
  );
  always #5 clk = ~clk;
  assign d_i = mem[a[7:0]];
  always @(posedge we_n)
    if (ce_n === 1'b0) begin
      if (!lb_n) mem[a[7:0]][7:0] = d_o[7:0];
      if (!ub_n) mem[a[7:0]][15:8] = d_o[15:8];
    end
  always @(negedge clk) begin
    checks = checks + 2;
    assert (!(oe_n === 1'b0 && we_n === 1'b0)) else begin
      failures++;
      $error("FAIL oe_we_overlap oe_n=%b we_n=%b", oe_n, we_n);
    end
    assert (!(d_oe === 1'b1 && oe_n === 1'b0)) else begin
      failures++;
      $error("FAIL doe_during_oe d_oe=%b oe_n=%b", d_oe, oe_n);
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic req(input logic w, input logic s, input logic [63:0] ad, input logic [15:0] dt);
    cyc = 1'b1; stb = 1'b1; we = w; siz = s; adr = ad; dat = dt;
    tick(1);
  endtask
  task automatic drop();
    cyc = 1'b0; stb = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h08] = 16'hA55A;
    tick(2);
    chk("rst_ack", ack, 0); chk("rst_dat", dat_o, 0); chk("rst_a", a, 0);
    chk("rst_ce", ce_n, 1); chk("rst_oe", oe_n, 1); chk("rst_we", we_n, 1);
    chk("rst_lanes", {lb_n, ub_n}, 2'b11); chk("rst_doe", d_oe, 0); chk("rst_do", d_o, 0);
    reset_ni = 1'b1;
    tick(1);
    req(1'b1, 1'b1, 64'h1234, 16'hBEEF);
    chk("w1_a", a, 19'h091A); chk("w1_ce", ce_n, 0); chk("w1_lanes", {lb_n, ub_n}, 2'b00);
    chk("w1_doe", d_oe, 1); chk("w1_do", d_o, 16'hBEEF); chk("w1_we_setup", we_n, 1);
    tick(1); chk("w1_we_a1", we_n, 0); chk("w1_doe_a1", d_oe, 1);
    tick(1); chk("w1_we_a2", we_n, 0);
    tick(1); chk("w1_we_hold", we_n, 1); chk("w1_ce_hold", ce_n, 0); chk("w1_doe_hold", d_oe, 1);
    tick(1); chk("w1_ack", ack, 1); chk("w1_ce_ack", ce_n, 1); chk("w1_doe_ack", d_oe, 0);
    drop();
    tick(1); chk("w1_ack_gone", ack, 0); chk("w1_mem", mem[8'h1A], 16'hBEEF);
    req(1'b0, 1'b0, 64'h0011, 16'h0000);
    chk("rb_lanes", {lb_n, ub_n}, 2'b10); chk("rb_oe_setup", oe_n, 1);
    tick(1); chk("rb_oe_a1", oe_n, 0); chk("rb_doe", d_oe, 0);
    tick(1); chk("rb_oe_a2", oe_n, 0);
    tick(1); chk("rb_oe_hold", oe_n, 1); chk("rb_dat_hold", dat_o, 16'h00A5);
    tick(1); chk("rb_ack", ack, 1); chk("rb_dat", dat_o, 16'h00A5);
    drop(); tick(1);
    req(1'b1, 1'b0, 64'h0010, 16'h0077);
    chk("wb_lanes", {lb_n, ub_n}, 2'b01); chk("wb_do", d_o, 16'h7777);
    tick(3);
    tick(1); chk("wb_ack", ack, 1);
    drop(); tick(1);
    chk("wb_mem", mem[8'h08], 16'hA577);
    req(1'b0, 1'b1, 64'h0010, 16'h0000);
    tick(3);
    tick(1); chk("rh_ack", ack, 1); chk("rh_dat", dat_o, 16'hA577);
    drop(); tick(1);
    req(1'b0, 1'b1, 64'h1234, 16'h0000);
    tick(3);
    tick(1); chk("bb_ack1", ack, 1); chk("bb_dat1", dat_o, 16'hBEEF);
    adr = 64'h0010;
    tick(1); chk("bb_idle_ack", ack, 0); chk("bb_idle_ce", ce_n, 1);
    tick(1); chk("bb_setup_ce", ce_n, 0);
    tick(2); chk("bb_dat_hold", dat_o, 16'hBEEF);
    tick(1); chk("bb_dat2", dat_o, 16'hA577); chk("bb_hold_ack", ack, 0);
    tick(1); chk("bb_ack2", ack, 1);
    drop(); tick(1);
    req(1'b1, 1'b1, 64'h0020, 16'h1111);
    tick(1); chk("ab_we_a1", we_n, 0);
    drop();
    tick(1); chk("ab_we_a2", we_n, 0);
    tick(1); chk("ab_we_hold", we_n, 1);
    tick(1); chk("ab_noack", ack, 0); chk("ab_ce_ack", ce_n, 1);
    tick(1); chk("ab_idle_ce", ce_n, 1); chk("ab_idle_ack", ack, 0);
    chk("ab_mem", mem[8'h10], 16'h1111);
    req(1'b0, 1'b1, 64'h1234, 16'h0000);
    tick(1); chk("rs_oe_before", oe_n, 0);
    #2 reset_ni = 1'b0;
    #1;
    chk("rs_oe", oe_n, 1); chk("rs_ce", ce_n, 1); chk("rs_we", we_n, 1);
    chk("rs_lanes", {lb_n, ub_n}, 2'b11); chk("rs_doe", d_oe, 0);
    chk("rs_ack", ack, 0); chk("rs_dat", dat_o, 0); chk("rs_a", a, 0);
    drop();
    #1 reset_ni = 1'b1;
    tick(1);
    req(1'b0, 1'b1, 64'h0020, 16'h0000);
    chk("rs2_a", a, 19'h00010);
    tick(3);
    tick(1); chk("rs2_ack", ack, 1); chk("rs2_dat", dat_o, 16'h1111);
    drop(); tick(1);
    chk("rs2_done", ack, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
